sema_grant_ctrl: RTL

- Responder end of the semaphore request bus.
- Every (on-chip IP, thread) requester presents a semaphore ID plus an acquire/release op.
- The block arbitrates round-robin, one request per cycle, and owns the semaphore lock/owner table.
- It returns a one-cycle response (GRANT / BUSY / ERR) to the winning requester.
- It sits between the IP request bundles (mcu, wl) and the shared-resource logic that consumes the lock status.

---
 rtl/sema_pkg.sv | 41 ++++
 rtl/sema_rr_arb.sv | 56 +++++
 rtl/sema_grant_ctrl.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/sema_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sema_pkg
// Description : Shared constants, types and helpers for the semaphore grant
//               controller: request bundle shapes, response codes and the
//               stage-1 capture record.
// Revision    : 1.0 - initial release
// ============================================================================
package sema_pkg;

    localparam int SEMA_WIDTH     = 8;
    localparam int NUM_THREADS    = 2;
    localparam int NUM_ON_CHIP_IP = 2;   // index 1 = mcu, 0 = wl
    localparam int NUM_SEMAS      = 16;
    localparam int NUM_REQ        = NUM_ON_CHIP_IP * NUM_THREADS;
    localparam int IDX_WIDTH      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SIDX_WIDTH     = (NUM_SEMAS > 1) ? $clog2(NUM_SEMAS) : 1;

    typedef logic [SEMA_WIDTH-1:0]           sema_t;
    typedef sema_t       [NUM_THREADS-1:0]    semathread_t;
    typedef semathread_t [NUM_ON_CHIP_IP-1:0] semathreadip_t;
    typedef logic [IDX_WIDTH-1:0]            req_idx_t;

    typedef enum logic [1:0] {
        GRANT = 2'd0,
        BUSY  = 2'd1,
        ERR   = 2'd2
    } sema_rsp_e;

    typedef struct packed {
        req_idx_t idx;   // flat requester index ip*NUM_THREADS+thr
        logic     rel;   // 1 = release, 0 = acquire
        sema_t    id;
    } sema_stage_t;

    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input req_idx_t idx);
        return NUM_REQ'(1) << idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sema_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : sema_rr_arb
// Description : Round-robin arbiter. Searches the request vector starting at
//               an internal pointer and returns a one-hot grant plus its
//               index. Every grant is a capture, so the pointer moves to the
//               slot after the winner on each granting cycle.
// Ports       : clk       - clock, rising edge
//               rst       - asynchronous active-high reset (pointer -> 0)
//               i_req     - request vector (already masked by the caller)
//               o_gnt     - one-hot grant
//               o_gnt_idx - index of the granted request
//               o_gnt_vld - a grant was issued this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module sema_rr_arb #(
    parameter  int NUM_REQ   = 4,
    localparam int IDX_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   i_req,
    output logic [NUM_REQ-1:0]   o_gnt,
    output logic [IDX_WIDTH-1:0] o_gnt_idx,
    output logic                 o_gnt_vld
);

    logic [IDX_WIDTH-1:0] r_ptr;
    logic [IDX_WIDTH-1:0] w_cand;

    // First requesting slot at or after the pointer, wrapping modulo NUM_REQ.
    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        o_gnt_vld = 1'b0;
        w_cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = IDX_WIDTH'((int'(r_ptr) + k) % NUM_REQ);
            if (!o_gnt_vld && i_req[w_cand]) begin
                o_gnt_vld     = 1'b1;
                o_gnt_idx     = w_cand;
                o_gnt[w_cand] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (o_gnt_vld) begin
            r_ptr <= (o_gnt_idx == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : o_gnt_idx + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sema_grant_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sema_grant_ctrl
// Description : Responder end of the semaphore request bus. Arbitrates the
//               (IP, thread) requesters round-robin, one capture per cycle,
//               owns the lock/owner table and returns a one-cycle response
//               (GRANT / BUSY / ERR) to the served requester.
//               Stage 1 holds the captured request; stage 2 reads/updates
//               the table and registers the response.
// Ports       : clk          - clock, rising edge
//               reset        - asynchronous active-high reset
//               semareq_id   - requested semaphore ID, indexed [ip][thr]
//               semareq_vld  - request valid per requester
//               semareq_rel  - 1 = release, 0 = acquire
//               semarsp_vld  - one-hot response strobe (one cycle)
//               semarsp_code - 0 GRANT, 1 BUSY, 2 ERR (valid with strobe)
//               sema_locked  - lock status per semaphore
//               sema_owner   - owner requester index per semaphore
// Revision    : 1.0 - initial release
// ============================================================================
module sema_grant_ctrl
    import sema_pkg::*;
(
    input  logic                                 clk,
    input  logic                                 reset,
    input  semathreadip_t                        semareq_id,
    input  logic [NUM_REQ-1:0]                   semareq_vld,
    input  logic [NUM_REQ-1:0]                   semareq_rel,
    output logic [NUM_REQ-1:0]                   semarsp_vld,
    output logic [1:0]                           semarsp_code,
    output logic [NUM_SEMAS-1:0]                 sema_locked,
    output logic [NUM_SEMAS-1:0][IDX_WIDTH-1:0]  sema_owner
);

    // ---------------------------------------------------------------- state
    logic                                r_s1_vld;
    sema_stage_t                         r_s1;
    logic [NUM_REQ-1:0]                  r_rsp_vld;
    sema_rsp_e                           r_rsp_code;
    logic [NUM_SEMAS-1:0]                r_locked;
    logic [NUM_SEMAS-1:0][IDX_WIDTH-1:0] r_owner;

    // ---------------------------------------------------------- arbitration
    logic [NUM_REQ-1:0]            w_mask;
    logic [NUM_REQ-1:0]            w_req;
    logic [NUM_REQ-1:0]            w_gnt;
    req_idx_t                      w_gnt_idx;
    logic                          w_gnt_vld;
    logic [NUM_REQ*SEMA_WIDTH-1:0] w_id_flat;
    sema_stage_t                   w_s1_next;

    // A requester already in flight (stage 1) or whose response is on the
    // bus this cycle still has vld high; serving it again would double-book.
    assign w_mask = (r_s1_vld ? idx_to_onehot(r_s1.idx) : '0) | r_rsp_vld;
    assign w_req  = semareq_vld & ~w_mask;

    sema_rr_arb #(
        .NUM_REQ   (NUM_REQ)
    ) u_arb (
        .clk       (clk),
        .rst       (reset),
        .i_req     (w_req),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx),
        .o_gnt_vld (w_gnt_vld)
    );

    // Packed [ip][thr] flattens so requester r occupies slice r*SEMA_WIDTH.
    assign w_id_flat     = semareq_id;
    assign w_s1_next.idx = w_gnt_idx;
    assign w_s1_next.rel = |(semareq_rel & w_gnt);
    assign w_s1_next.id  = w_id_flat[w_gnt_idx*SEMA_WIDTH +: SEMA_WIDTH];

    // ------------------------------------------------------ table decision
    logic [SIDX_WIDTH-1:0] w_sidx;
    logic                  w_id_ok;
    logic                  w_cur_locked;
    logic                  w_owner_match;
    logic                  w_set;
    logic                  w_clr;
    sema_rsp_e             w_code;

    assign w_id_ok       = (32'(r_s1.id) < NUM_SEMAS);
    assign w_sidx        = r_s1.id[SIDX_WIDTH-1:0];
    assign w_cur_locked  = r_locked[w_sidx];
    assign w_owner_match = (r_owner[w_sidx] == r_s1.idx);

    always_comb begin
        w_code = GRANT;
        w_set  = 1'b0;
        w_clr  = 1'b0;
        if (!w_id_ok) begin
            w_code = ERR;
        end else if (!r_s1.rel) begin
            if (!w_cur_locked) begin
                w_code = GRANT;
                w_set  = r_s1_vld;
            end else if (w_owner_match) begin
                w_code = GRANT;                 // re-acquire by owner is a no-op
            end else begin
                w_code = BUSY;
            end
        end else begin
            if (w_cur_locked && w_owner_match) begin
                w_code = GRANT;
                w_clr  = r_s1_vld;
            end else begin
                w_code = ERR;
            end
        end
    end

    // ------------------------------------------------------------ registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_vld   <= 1'b0;
            r_s1       <= '0;
            r_rsp_vld  <= '0;
            r_rsp_code <= GRANT;
            r_locked   <= '0;
            r_owner    <= '0;
        end else begin
            r_s1_vld <= w_gnt_vld;
            if (w_gnt_vld) begin
                r_s1 <= w_s1_next;
            end
            r_rsp_vld  <= r_s1_vld ? idx_to_onehot(r_s1.idx) : '0;
            r_rsp_code <= r_s1_vld ? w_code : GRANT;
            if (w_set) begin
                r_locked[w_sidx] <= 1'b1;
                r_owner[w_sidx]  <= r_s1.idx;
            end
            if (w_clr) begin
                r_locked[w_sidx] <= 1'b0;
            end
        end
    end

    assign semarsp_vld  = r_rsp_vld;
    assign semarsp_code = r_rsp_code;
    assign sema_locked  = r_locked;
    assign sema_owner   = r_owner;

endmodule
`default_nettype wire
